// File: rtl/pico_irq_pkg.sv
// Shared types and sizing helpers for the pico interrupt controller.
// PICO_IRQ_RR_EN (optional define) switches the selector to round-robin.
package pico_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Width of a source index; a single source still needs one bit.
    function automatic int vec_w(input int irq_cnt);
        return (irq_cnt > 1) ? $clog2(irq_cnt) : 1;
    endfunction

    // The vector register flags a valid request in its top bit.
    function automatic int valid_bit(input int io_width);
        return io_width - 1;
    endfunction

endpackage

// File: rtl/pico_irq_sel.sv
// Combinational request selector: lowest index wins, or with PICO_IRQ_RR_EN
// the search starts at rr_ptr and wraps.
module pico_irq_sel
    import pico_irq_pkg::*;
#(
    parameter int IRQ_CNT = 8,
    parameter int VEC_W   = vec_w(IRQ_CNT)
) (
    input  logic [IRQ_CNT-1:0] req,
`ifdef PICO_IRQ_RR_EN
    input  logic [VEC_W-1:0]   rr_ptr,
`endif
    output logic               found,
    output logic [VEC_W-1:0]   idx
);

    // Scan from the far end so the last hit written is the winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = IRQ_CNT - 1; i >= 0; i--) begin
`ifdef PICO_IRQ_RR_EN
            int j;
            j = (int'(rr_ptr) + i) % IRQ_CNT;
`else
            int j;
            j = i;
`endif
            if (req[j[VEC_W-1:0]]) begin
                found = 1'b1;
                idx   = j[VEC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pico_irq_ctrl.sv
// Edge-triggered interrupt controller for the pico_wrapper interrupt/ack pair.
// Optional define PICO_IRQ_RR_EN selects round-robin arbitration.
module pico_irq_ctrl
    import pico_irq_pkg::*;
#(
    parameter int IRQ_CNT       = 8,
    parameter int PICO_IO_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IRQ_CNT-1:0]       irq_src,
    input  logic [PICO_IO_WIDTH-1:0] cfg_wdata,
    input  logic                     mask_we,
    input  logic                     clr_we,
    input  logic                     eoi_we,
    output logic                     interrupt,
    input  logic                     interrupt_ack,
    output logic [PICO_IO_WIDTH-1:0] irq_vector,
    output logic [PICO_IO_WIDTH-1:0] irq_pending,
    output logic [PICO_IO_WIDTH-1:0] irq_mask
);

    localparam int VEC_W     = vec_w(IRQ_CNT);
    localparam int VALID_BIT = valid_bit(PICO_IO_WIDTH);

    irq_state_t                 state_reg;
    logic [IRQ_CNT-1:0]         prev_src_reg;
    logic [IRQ_CNT-1:0]         pending_reg, pending_next;
    logic [IRQ_CNT-1:0]         mask_reg;
    logic [VEC_W-1:0]           idx_reg;
    logic                       interrupt_reg;
    logic [PICO_IO_WIDTH-1:0]   irq_vector_reg, vector_next;
    logic [IRQ_CNT-1:0]         src_edge;
    logic                       ack_take;
    logic                       sel_found;
    logic [VEC_W-1:0]           sel_idx;
    logic                       unused_cfg;

    assign src_edge   = irq_src & ~prev_src_reg;
    assign ack_take   = (state_reg == ASSERT) && interrupt_ack;
    assign unused_cfg = &{1'b0, cfg_wdata};

    // A fresh edge outranks both the ack clear and the firmware clear.
    genvar gi;
    generate
        for (gi = 0; gi < IRQ_CNT; gi++) begin : g_pend
            assign pending_next[gi] = src_edge[gi]
                | (pending_reg[gi]
                   & ~(clr_we & cfg_wdata[gi])
                   & ~(ack_take & (idx_reg == VEC_W'(gi))));
        end
    endgenerate

`ifdef PICO_IRQ_RR_EN
    logic [VEC_W-1:0] rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (ack_take) begin
            rr_ptr_reg <= (idx_reg == VEC_W'(IRQ_CNT - 1)) ? '0 : idx_reg + 1'b1;
        end
    end

    pico_irq_sel #(.IRQ_CNT(IRQ_CNT), .VEC_W(VEC_W)) u_sel (
        .req    (pending_reg & mask_reg),
        .rr_ptr (rr_ptr_reg),
        .found  (sel_found),
        .idx    (sel_idx)
    );
`else
    pico_irq_sel #(.IRQ_CNT(IRQ_CNT), .VEC_W(VEC_W)) u_sel (
        .req    (pending_reg & mask_reg),
        .found  (sel_found),
        .idx    (sel_idx)
    );
`endif

    always_comb begin
        vector_next            = PICO_IO_WIDTH'(sel_idx);
        vector_next[VALID_BIT] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_src_reg <= '0;
            pending_reg  <= '0;
            mask_reg     <= '0;
        end else begin
            prev_src_reg <= irq_src;
            pending_reg  <= pending_next;
            if (mask_we) begin
                mask_reg <= cfg_wdata[IRQ_CNT-1:0];
            end
        end
    end

    // idx_reg is frozen from selection until EOI so later pending/mask
    // traffic cannot retarget the request being serviced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            interrupt_reg  <= 1'b0;
            irq_vector_reg <= '0;
            idx_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        state_reg      <= ASSERT;
                        interrupt_reg  <= 1'b1;
                        idx_reg        <= sel_idx;
                        irq_vector_reg <= vector_next;
                    end
                end
                ASSERT: begin
                    if (interrupt_ack) begin
                        state_reg     <= SERVICE;
                        interrupt_reg <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi_we) begin
                        state_reg      <= IDLE;
                        irq_vector_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign interrupt   = interrupt_reg;
    assign irq_vector  = irq_vector_reg;
    assign irq_pending = PICO_IO_WIDTH'(pending_reg);
    assign irq_mask    = PICO_IO_WIDTH'(mask_reg);

endmodule

// File: tb/tb_pico_irq_ctrl.sv
// Directed bench for pico_irq_ctrl with a cycle-level reference model
// compared on every falling edge; honours PICO_IRQ_RR_EN like the design.
module tb_pico_irq_ctrl;

    localparam int IRQ_CNT = 8;
    localparam int W       = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   irq_src = '0;
    logic [7:0]   cfg_wdata = '0;
    logic         mask_we = 1'b0;
    logic         clr_we = 1'b0;
    logic         eoi_we = 1'b0;
    logic         interrupt_ack = 1'b0;
    logic         interrupt;
    logic [7:0]   irq_vector;
    logic [7:0]   irq_pending;
    logic [7:0]   irq_mask;

    int checks = 0;
    int errors = 0;

    pico_irq_ctrl #(.IRQ_CNT(IRQ_CNT), .PICO_IO_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src       (irq_src),
        .cfg_wdata     (cfg_wdata),
        .mask_we       (mask_we),
        .clr_we        (clr_we),
        .eoi_we        (eoi_we),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .irq_vector    (irq_vector),
        .irq_pending   (irq_pending),
        .irq_mask      (irq_mask)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = nothing outstanding, 1 = request raised awaiting ack,
    // 2 = taken by the core and awaiting EOI.
    logic [7:0] m_pend, m_mask, m_prev;
    int         m_phase, m_cur, m_rr;
    bit         model_valid = 1'b0;

    function automatic int pick(input logic [7:0] req, input int start);
        for (int i = 0; i < IRQ_CNT; i++) begin
            int j;
`ifdef PICO_IRQ_RR_EN
            j = (start + i) % IRQ_CNT;
`else
            j = i;
`endif
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] edges, np;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_prev = '0;
            m_phase = 0; m_cur = 0; m_rr = 0;
            model_valid = 1'b1;
            return;
        end
        edges = irq_src & ~m_prev;
        np    = m_pend;
        if (clr_we) np = np & ~cfg_wdata;
        if (m_phase == 0) begin
            int p;
            p = pick(m_pend & m_mask, m_rr);
            if (p >= 0) begin
                m_cur   = p;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (interrupt_ack) begin
                np[m_cur] = 1'b0;
                m_phase   = 2;
                m_rr      = (m_cur + 1) % IRQ_CNT;
            end
        end else if (eoi_we) begin
            m_phase = 0;
        end
        np = np | edges;
        if (mask_we) m_mask = cfg_wdata;
        m_pend = np;
        m_prev = irq_src;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [7:0] exp_vec;
            exp_vec = (m_phase != 0) ? (8'h80 | 8'(m_cur)) : 8'h00;
            check("cyc_interrupt", {7'd0, interrupt}, {7'd0, (m_phase == 1)});
            check("cyc_vector", irq_vector, exp_vec);
            check("cyc_pending", irq_pending, m_pend);
            check("cyc_mask", irq_mask, m_mask);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [7:0] v);
        cfg_wdata = v; mask_we = 1'b1; tick(); mask_we = 1'b0;
        $display("txn mask_we   data=0x%02h", v);
    endtask

    task automatic write_clr(input logic [7:0] v);
        cfg_wdata = v; clr_we = 1'b1; tick(); clr_we = 1'b0;
        $display("txn clr_we    data=0x%02h", v);
    endtask

    task automatic pulse_src(input logic [7:0] v);
        irq_src = v; tick(); irq_src = '0;
        $display("txn irq_src   edges=0x%02h", v);
    endtask

    task automatic do_ack();
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
        $display("txn ack");
    endtask

    task automatic do_eoi();
        eoi_we = 1'b1; tick(); eoi_we = 1'b0;
        $display("txn eoi");
    endtask

    // Service everything that is enabled, bounded by a cycle budget.
    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (interrupt) do_ack();
            else if (irq_vector[7]) do_eoi();
            else if ((irq_pending & irq_mask) != 0) tick();
            else return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: controller still busy after 40 cycles");
    endtask

    initial begin
        logic [7:0] exp_rr;
        // 1: reset, single enabled source
        tick(); tick();
        rst = 1'b0;
        $display("txn reset released");
        check("rst_interrupt", {7'd0, interrupt}, 8'h00);
        check("rst_vector", irq_vector, 8'h00);
        check("rst_pending", irq_pending, 8'h00);
        check("rst_mask", irq_mask, 8'h00);
        write_mask(8'h05);
        check("t1_mask", irq_mask, 8'h05);
        pulse_src(8'h04);
        check("t1_pend", irq_pending, 8'h04);
        check("t1_int_early", {7'd0, interrupt}, 8'h00);
        tick();
        check("t1_int", {7'd0, interrupt}, 8'h01);
        check("t1_vec", irq_vector, 8'h82);
        do_ack();
        check("t1_int_ack", {7'd0, interrupt}, 8'h00);
        check("t1_pend_ack", irq_pending, 8'h00);
        check("t1_vec_svc", irq_vector, 8'h82);
        do_eoi();
        check("t1_vec_eoi", irq_vector, 8'h00);

        // 2: simultaneous sources, arbitration order
        pulse_src(8'h05);
        tick();
        check("t2_vec_first", irq_vector, 8'h80);
        do_ack();
        do_eoi();
        tick();
        check("t2_vec_second", irq_vector, 8'h82);
        do_ack();
        pulse_src(8'h05);
        do_eoi();
        tick();
        check("t2_vec_third", irq_vector, 8'h80);
        do_ack();
        pulse_src(8'h01);
        do_eoi();
        tick();
`ifdef PICO_IRQ_RR_EN
        exp_rr = 8'h82;
`else
        exp_rr = 8'h80;
`endif
        check("t2_vec_arb", irq_vector, exp_rr);
        drain();
        write_clr(8'hFF);

        // 3: masked source, then enabled
        pulse_src(8'h08);
        check("t3_pend", irq_pending, 8'h08);
        tick();
        check("t3_no_int", {7'd0, interrupt}, 8'h00);
        write_mask(8'h08);
        check("t3_int_oldmask", {7'd0, interrupt}, 8'h00);
        tick();
        check("t3_int", {7'd0, interrupt}, 8'h01);
        check("t3_vec", irq_vector, 8'h83);

        // 4: edge coincident with ack keeps pending
        irq_src = 8'h08; interrupt_ack = 1'b1; tick();
        irq_src = '0; interrupt_ack = 1'b0;
        $display("txn ack + irq_src edges=0x08");
        check("t4_pend", irq_pending, 8'h08);
        check("t4_int", {7'd0, interrupt}, 8'h00);
        do_eoi();
        tick();
        check("t4_reint", {7'd0, interrupt}, 8'h01);
        check("t4_vec", irq_vector, 8'h83);
        drain();

        // 5: stray strobes while idle, clear, and set-vs-clear race
        interrupt_ack = 1'b1; eoi_we = 1'b1; tick();
        interrupt_ack = 1'b0; eoi_we = 1'b0;
        $display("txn ack + eoi while idle");
        check("t5_int", {7'd0, interrupt}, 8'h00);
        check("t5_vec", irq_vector, 8'h00);
        write_mask(8'h00);
        pulse_src(8'h08);
        write_clr(8'h08);
        check("t5_clr", irq_pending, 8'h00);
        irq_src = 8'h08; cfg_wdata = 8'h08; clr_we = 1'b1; tick();
        irq_src = '0; clr_we = 1'b0;
        $display("txn clr_we + irq_src edges=0x08");
        check("t5_set_wins", irq_pending, 8'h08);

        // 6: reset during an asserted request
        write_mask(8'h08);
        tick();
        check("t6_int", {7'd0, interrupt}, 8'h01);
        rst = 1'b1; tick(); rst = 1'b0;
        $display("txn reset mid-assert");
        check("t6_int_rst", {7'd0, interrupt}, 8'h00);
        check("t6_vec_rst", irq_vector, 8'h00);
        check("t6_pend_rst", irq_pending, 8'h00);
        check("t6_mask_rst", irq_mask, 8'h00);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
